sigmoid_lut_addr_calc: RTL and testbench



---
 rtl/sigmoid_lut_addr_calc.sv | 60 ++++++
 tb/tb_sigmoid_lut_addr_calc.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sigmoid_lut_addr_calc.sv
// Sigmoid LUT address generator: saturating magnitude-to-address map plus sign and out-of-range flag.
// One-cycle latency, one operand per cycle; no backpressure, outputs hold between valid inputs.
module sigmoid_lut_addr_calc #(
  parameter int DATA_W    = 12,
  parameter int ADDR_W    = 9,
  parameter int FRAC_BITS = 6,
  parameter int MAX_MAG   = 384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  output logic [ADDR_W-1:0] addr_out,
  output logic              out_of_range,
  output logic              sign_out
);

  localparam int MAG_W = DATA_W - 1;
  localparam int INT_W = MAG_W - FRAC_BITS;
  localparam logic [INT_W-1:0]     MAX_INT  = INT_W'(MAX_MAG >> FRAC_BITS);
  localparam logic [FRAC_BITS-1:0] MAX_FRAC = FRAC_BITS'(MAX_MAG % (1 << FRAC_BITS));
  localparam logic [ADDR_W-1:0]    SAT_ADDR = ADDR_W'(MAX_MAG);

  logic [MAG_W-1:0]     mag;
  logic [INT_W-1:0]     mag_int;
  logic [FRAC_BITS-1:0] mag_frac;
  logic                 oor_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic                 sign_nxt;

  assign mag      = data_in[MAG_W-1:0];
  assign mag_int  = mag[MAG_W-1:FRAC_BITS];
  assign mag_frac = mag[FRAC_BITS-1:0];

  // Compare the full magnitude against the limit so large values saturate rather than wrap.
  always_comb begin
    oor_nxt  = (mag_int > MAX_INT) || ((mag_int == MAX_INT) && (mag_frac > MAX_FRAC));
    addr_nxt = oor_nxt ? SAT_ADDR : mag[ADDR_W-1:0];
    // Negative zero is folded to +0 so the LUT never applies the 1-s(x) mirror to zero.
    sign_nxt = data_in[DATA_W-1] && (mag != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      addr_out     <= '0;
      out_of_range <= 1'b0;
      sign_out     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        addr_out     <= addr_nxt;
        out_of_range <= oor_nxt;
        sign_out     <= sign_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_lut_addr_calc.sv
// Directed bench for sigmoid_lut_addr_calc with a behavioural reference model checked every cycle.
module tb_sigmoid_lut_addr_calc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] data_in = '0;
  logic        out_valid;
  logic [8:0]  addr_out;
  logic        out_of_range;
  logic        sign_out;

  int n_checks = 0;
  int n_fail   = 0;

  sigmoid_lut_addr_calc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .addr_out     (addr_out),
    .out_of_range (out_of_range),
    .sign_out     (sign_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: saturating magnitude map, registered and held while in_valid is low.
  logic       m_vld;
  int         m_addr;
  logic       m_oor;
  logic       m_sign;
  int         m_mag;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld = 1'b0; m_addr = 0; m_oor = 1'b0; m_sign = 1'b0;
    end else begin
      m_vld = in_valid;
      if (in_valid) begin
        m_mag  = int'(data_in) % 2048;
        m_oor  = (m_mag > 384);
        m_addr = m_oor ? 384 : m_mag;
        m_sign = (data_in >= 12'h800) && (m_mag != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_vld",  {31'd0, out_valid},    {31'd0, m_vld});
      check("model_addr", {23'd0, addr_out},     m_addr);
      check("model_oor",  {31'd0, out_of_range}, {31'd0, m_oor});
      check("model_sign", {31'd0, sign_out},     {31'd0, m_sign});
    end
  end

  task automatic step(input logic [11:0] d, input logic v, input logic e_vld,
                      input int e_addr, input logic e_oor, input logic e_sign);
    data_in  = d;
    in_valid = v;
    @(posedge clk);
    #1;
    check("vld",  {31'd0, out_valid},    {31'd0, e_vld});
    check("addr", {23'd0, addr_out},     e_addr);
    check("oor",  {31'd0, out_of_range}, {31'd0, e_oor});
    check("sign", {31'd0, sign_out},     {31'd0, e_sign});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"},  {31'd0, out_valid},    0);
    check({tag, "_addr"}, {23'd0, addr_out},     0);
    check({tag, "_oor"},  {31'd0, out_of_range}, 0);
    check({tag, "_sign"}, {31'd0, sign_out},     0);
  endtask

  initial begin
    #1;
    check_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Mid-stream reset with in_valid held high.
    step(12'h0C0, 1'b1, 1'b1, 192, 1'b0, 1'b0);
    step(12'h8C0, 1'b1, 1'b1, 192, 1'b0, 1'b1);
    data_in = 12'h0C0; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk); #1;
    check_zero("rst_hold");
    rst_n = 1'b1;
    step(12'h0C0, 1'b1, 1'b1, 192, 1'b0, 1'b0);

    // Small magnitudes and negative zero.
    step(12'h000, 1'b1, 1'b1, 0,   1'b0, 1'b0);
    step(12'h020, 1'b1, 1'b1, 32,  1'b0, 1'b0);
    step(12'h820, 1'b1, 1'b1, 32,  1'b0, 1'b1);
    step(12'h800, 1'b1, 1'b1, 0,   1'b0, 1'b0);
    // Mid range.
    step(12'h0C0, 1'b1, 1'b1, 192, 1'b0, 1'b0);
    step(12'h8C0, 1'b1, 1'b1, 192, 1'b0, 1'b1);
    // Range edge.
    step(12'h180, 1'b1, 1'b1, 384, 1'b0, 1'b0);
    step(12'h980, 1'b1, 1'b1, 384, 1'b0, 1'b1);
    step(12'h181, 1'b1, 1'b1, 384, 1'b1, 1'b0);
    // Overflow, including a value that would alias to 0 if truncated.
    step(12'h200, 1'b1, 1'b1, 384, 1'b1, 1'b0);
    step(12'hA00, 1'b1, 1'b1, 384, 1'b1, 1'b1);
    step(12'h7FF, 1'b1, 1'b1, 384, 1'b1, 1'b0);
    step(12'h9C0, 1'b1, 1'b1, 384, 1'b1, 1'b1);
    step(12'h001, 1'b1, 1'b1, 1,   1'b0, 1'b0);
    // Valid gating: outputs hold during the idle cycle.
    step(12'h020, 1'b1, 1'b1, 32,  1'b0, 1'b0);
    step(12'h0C0, 1'b1, 1'b1, 192, 1'b0, 1'b0);
    step(12'h180, 1'b0, 1'b0, 192, 1'b0, 1'b0);
    step(12'hFFF, 1'b0, 1'b0, 192, 1'b0, 1'b0);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 60; i++) begin
      data_in  = 12'($urandom_range(0, 4095));
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
